// File: rtl/mem_bank_ctrl.sv
// Load/store adapter for a 4 KB data memory made of four byte-lane SRAMs.
// Accepts one request at a time: byte/half/word strobes out, aligned and extended load data back.
module mem_bank_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  mem_ceb,
    output logic [3:0]  mem_web,
    output logic [3:0]  mem_write_en,
    output logic [9:0]  mem_a,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        size_err;
    logic        align_err;
    logic        window_err;
    logic        req_illegal;
    logic [3:0]  lane_sel;
    logic [31:0] rd_data_d;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && (state_q == IDLE);

    assign size_err    = (req_size == 2'd3);
    assign align_err   = ((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign window_err  = (req_addr[31:12] != BASE_ADDR[31:12]);
    assign req_illegal = size_err || align_err || window_err;

    always_comb begin
        lane_sel = 4'h0;
        unique case (req_size)
            SZ_BYTE: lane_sel = 4'b0001 << req_addr[1:0];
            SZ_HALF: lane_sel = req_addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_sel = 4'b1111;
            default: lane_sel = 4'h0;
        endcase
    end

    // Write data is replicated across lanes so the lane strobes alone pick the destination.
    always_comb begin
        mem_d = req_wdata;
        unique case (req_size)
            SZ_BYTE: mem_d = {4{req_wdata[7:0]}};
            SZ_HALF: mem_d = {2{req_wdata[15:0]}};
            default: mem_d = req_wdata;
        endcase
    end

    assign mem_a = req_addr[11:2];

    always_comb begin
        mem_ceb      = 4'hF;
        mem_web      = 4'hF;
        mem_write_en = 4'h0;
        if (accept && !req_illegal) begin
            mem_ceb = 4'h0;
            if (req_we) begin
                mem_web      = 4'h0;
                mem_write_en = lane_sel;
            end
        end
    end

    // Load formatting works from the offset/size captured at acceptance, since req_* may have moved on.
    always_comb begin
        logic [7:0]  rd_byte;
        logic [15:0] rd_half;
        rd_byte   = mem_q[{off_q, 3'b000} +: 8];
        rd_half   = off_q[1] ? mem_q[31:16] : mem_q[15:0];
        rd_data_d = mem_q;
        unique case (size_q)
            SZ_BYTE: rd_data_d = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            SZ_HALF: rd_data_d = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: rd_data_d = mem_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_illegal || req_we) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_err_q   <= req_illegal;
                        end else begin
                            state_q <= RD;
                            off_q   <= req_addr[1:0];
                            size_q  <= req_size;
                            uns_q   <= req_unsigned;
                        end
                    end
                end
                RD: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_data_d;
                    rsp_err_q   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl with a behavioural four-lane byte memory behind it.
module tb_mem_bank_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  mem_ceb;
    logic [3:0]  mem_web;
    logic [3:0]  mem_write_en;
    logic [9:0]  mem_a;
    logic [31:0] mem_d;
    logic [31:0] mem_q = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] word_mem [1024] = '{default: '0};

    always #5 clk = ~clk;

    mem_bank_ctrl #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_ceb      (mem_ceb),
        .mem_web      (mem_web),
        .mem_write_en (mem_write_en),
        .mem_a        (mem_a),
        .mem_d        (mem_d),
        .mem_q        (mem_q)
    );

    // Byte-lane SRAM model: write on ceb=0/web=0 gated by write_en, registered read on ceb=0/web=1.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!mem_ceb[n]) begin
                if (!mem_web[n]) begin
                    if (mem_write_en[n]) word_mem[mem_a][8*n +: 8] <= mem_d[8*n +: 8];
                end else begin
                    mem_q[8*n +: 8] <= word_mem[mem_a][8*n +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input logic [3:0] exp_we,
                            input logic [31:0] exp_d);
        drive(1'b1, addr, size, 1'b0, wdata);
        #2;
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, ".ceb"}, {28'h0, mem_ceb}, 32'h0);
        check({tag, ".web"}, {28'h0, mem_web}, 32'h0);
        check({tag, ".we"}, {28'h0, mem_write_en}, {28'h0, exp_we});
        check({tag, ".a"}, {22'h0, mem_a}, {22'h0, addr[11:2]});
        check({tag, ".d"}, mem_d, exp_d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".valid_t1"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ".err"}, {31'h0, rsp_err}, 32'h0);
        check({tag, ".rdata"}, rsp_rdata, 32'h0);
        @(posedge clk); #1;
        check({tag, ".idle"}, {31'h0, req_ready}, 32'h1);
        $display("store %s addr=0x%08h size=%0d wdata=0x%08h", tag, addr, size, wdata);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] exp_data);
        drive(1'b0, addr, size, uns, 32'h0);
        #2;
        check({tag, ".ceb"}, {28'h0, mem_ceb}, 32'h0);
        check({tag, ".web"}, {28'h0, mem_web}, 32'hF);
        check({tag, ".we"}, {28'h0, mem_write_en}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".valid_t1"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, ".ceb_rd"}, {28'h0, mem_ceb}, 32'hF);
        @(posedge clk); #1;
        check({tag, ".valid_t2"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ".err"}, {31'h0, rsp_err}, 32'h0);
        check({tag, ".rdata"}, rsp_rdata, exp_data);
        @(posedge clk); #1;
        check({tag, ".idle"}, {31'h0, req_ready}, 32'h1);
        $display("load  %s addr=0x%08h size=%0d uns=%0d rdata=0x%08h", tag, addr, size, uns, rsp_rdata);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size);
        drive(we, addr, size, 1'b0, 32'h1234_5678);
        #2;
        check({tag, ".ceb"}, {28'h0, mem_ceb}, 32'hF);
        check({tag, ".we"}, {28'h0, mem_write_en}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".valid_t1"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ".err"}, {31'h0, rsp_err}, 32'h1);
        check({tag, ".rdata"}, rsp_rdata, 32'h0);
        @(posedge clk); #1;
        check({tag, ".idle"}, {31'h0, req_ready}, 32'h1);
        $display("error %s we=%0d addr=0x%08h size=%0d err=%0d", tag, we, addr, size, rsp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", {31'h0, rsp_valid}, 32'h0);
        check("rst.rdata", rsp_rdata, 32'h0);
        check("rst.err", {31'h0, rsp_err}, 32'h0);
        check("rst.ceb", {28'h0, mem_ceb}, 32'hF);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst.ready", {31'h0, req_ready}, 32'h1);

        do_store("sw10", 32'h0000_0010, 2'd2, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
        do_load("lw10", 32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF);
        do_store("sb13", 32'h0000_0013, 2'd0, 32'h0000_0080, 4'b1000, 32'h8080_8080);
        do_load("lb13", 32'h0000_0013, 2'd0, 1'b0, 32'hFFFF_FF80);
        do_load("lbu13", 32'h0000_0013, 2'd0, 1'b1, 32'h0000_0080);
        do_load("lw10b", 32'h0000_0010, 2'd2, 1'b0, 32'h80AD_BEEF);
        do_load("lh12", 32'h0000_0012, 2'd1, 1'b0, 32'hFFFF_80AD);
        do_load("lhu10", 32'h0000_0010, 2'd1, 1'b1, 32'h0000_BEEF);
        do_load("lb11", 32'h0000_0011, 2'd0, 1'b0, 32'hFFFF_FFBE);
        do_store("sh16", 32'h0000_0016, 2'd1, 32'h0000_7A5C, 4'b1100, 32'h7A5C_7A5C);
        do_load("lh16", 32'h0000_0016, 2'd1, 1'b0, 32'h0000_7A5C);
        do_load("lw14", 32'h0000_0014, 2'd2, 1'b0, 32'h7A5C_0000);

        do_err("lh11", 1'b0, 32'h0000_0011, 2'd1);
        do_err("sw02", 1'b1, 32'h0000_0002, 2'd2);
        do_err("sz3", 1'b1, 32'h0000_0010, 2'd3);
        do_err("win1000", 1'b1, 32'h0000_1000, 2'd2);
        do_load("lw00", 32'h0000_0000, 2'd2, 1'b0, 32'h0000_0000);
        do_load("lw10c", 32'h0000_0010, 2'd2, 1'b0, 32'h80AD_BEEF);

        // Backpressure: hold the load response while a competing store sits on the request port.
        rsp_ready = 1'b0;
        drive(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'h1111_1111);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            check("bp.valid", {31'h0, rsp_valid}, 32'h1);
            check("bp.rdata", rsp_rdata, 32'h80AD_BEEF);
            check("bp.ready", {31'h0, req_ready}, 32'h0);
            check("bp.ceb", {28'h0, mem_ceb}, 32'hF);
            $display("bp cycle %0d valid=%0d rdata=0x%08h", c, rsp_valid, rsp_rdata);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #2;
        check("bp.valid_rel", {31'h0, rsp_valid}, 32'h1);
        @(posedge clk); #1;
        check("bp.idle", {31'h0, req_ready}, 32'h1);
        check("bp.valid_off", {31'h0, rsp_valid}, 32'h0);
        do_load("lw10d", 32'h0000_0010, 2'd2, 1'b0, 32'h80AD_BEEF);

        // Reset while the load sits in RD.
        drive(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid.in_rd", {31'h0, req_ready}, 32'h0);
        resetn = 1'b0;
        #1;
        check("rstmid.valid", {31'h0, rsp_valid}, 32'h0);
        check("rstmid.ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rstmid.valid_a", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        check("rstmid.valid_b", {31'h0, rsp_valid}, 32'h0);
        check("rstmid.ready_b", {31'h0, req_ready}, 32'h1);
        $display("reset mid-load valid=%0d ready=%0d", rsp_valid, req_ready);
        do_load("lw10e", 32'h0000_0010, 2'd2, 1'b0, 32'h80AD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
